// File: rtl/baud_gen_multi_pkg.sv
// Shared definitions for the fractional-N baud generator: rate constants,
// FSM state encoding and the elaboration-time increment calculation.
package baud_gen_multi_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } state_t;

  localparam int unsigned BAUD_RATE_0 = 1200;
  localparam int unsigned BAUD_RATE_1 = 2400;
  localparam int unsigned BAUD_RATE_2 = 4800;
  localparam int unsigned BAUD_RATE_3 = 9600;
  localparam int unsigned BAUD_RATE_4 = 19200;
  localparam int unsigned BAUD_RATE_5 = 38400;
  localparam int unsigned BAUD_RATE_6 = 57600;
  localparam int unsigned BAUD_RATE_7 = 115200;

  // Rounded phase increment; the >>8 pre-scaling keeps the product inside 32 bits.
  function automatic int unsigned baud_inc(input int unsigned rate, input int unsigned freq,
                                           input int unsigned os, input int unsigned w);
    return (((rate * os) << (w - 8)) + (freq >> 9)) / (freq >> 8);
  endfunction

endpackage

// File: rtl/baud_inc_rom.sv
// Combinational rate table: rate index -> accumulator increment.
// Entries are constants folded at elaboration.
module baud_inc_rom
  import baud_gen_multi_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int ACC_W      = 16,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_SIZE  = 3
) (
  input  logic [BAUD_SIZE-1:0] idx,
  output logic [ACC_W:0]       inc
);

  localparam int unsigned INC_0 = baud_inc(BAUD_RATE_0, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam int unsigned INC_1 = baud_inc(BAUD_RATE_1, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam int unsigned INC_2 = baud_inc(BAUD_RATE_2, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam int unsigned INC_3 = baud_inc(BAUD_RATE_3, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam int unsigned INC_4 = baud_inc(BAUD_RATE_4, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam int unsigned INC_5 = baud_inc(BAUD_RATE_5, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam int unsigned INC_6 = baud_inc(BAUD_RATE_6, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam int unsigned INC_7 = baud_inc(BAUD_RATE_7, CLK_FREQ, OVERSAMPLE, ACC_W);

  always_comb begin
    inc = INC_7[ACC_W:0];
    case (int'(idx))
      0:       inc = INC_0[ACC_W:0];
      1:       inc = INC_1[ACC_W:0];
      2:       inc = INC_2[ACC_W:0];
      3:       inc = INC_3[ACC_W:0];
      4:       inc = INC_4[ACC_W:0];
      5:       inc = INC_5[ACC_W:0];
      6:       inc = INC_6[ACC_W:0];
      default: inc = INC_7[ACC_W:0];
    endcase
  end

endmodule

// File: rtl/baud_gen_multi.sv
// Fractional-N baud generator with oversample/bit/mid strobes and glitch-free rate switching.
// Optional BAUD_GEN_CUSTOM_INC_EN adds a writable increment selected by the all-ones index.
//   state     | meaning
//   ST_RUN    | accumulating, ticks issued
//   ST_SWITCH | rate change draining: load new increment, then return (busy=1)
module baud_gen_multi
  import baud_gen_multi_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int ACC_W      = 16,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_SIZE  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BAUD_SIZE-1:0] baud_switch,
  input  logic                 sync_clr,
`ifdef BAUD_GEN_CUSTOM_INC_EN
  input  logic                 inc_wr,
  input  logic [ACC_W:0]       inc_wdata,
`endif
  output logic                 os_tick,
  output logic                 bit_tick,
  output logic                 mid_tick,
  output logic                 busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam int unsigned INC_RST_I = baud_inc(BAUD_RATE_0, CLK_FREQ, OVERSAMPLE, ACC_W);
  localparam logic [ACC_W:0] INC_RST = INC_RST_I[ACC_W:0];

  state_t               state;
  logic                 drain;
  logic [BAUD_SIZE-1:0] sel_q, active, target;
  logic [ACC_W:0]       acc, inc, rom_inc, next_inc, sum;
  logic                 carry;
  logic [OS_W-1:0]      os_cnt;
  logic                 force_sw;

  baud_inc_rom #(
    .CLK_FREQ  (CLK_FREQ),
    .ACC_W     (ACC_W),
    .OVERSAMPLE(OVERSAMPLE),
    .BAUD_SIZE (BAUD_SIZE)
  ) u_rom (
    .idx(target),
    .inc(rom_inc)
  );

  assign sum   = {1'b0, acc[ACC_W-1:0]} + inc;
  assign carry = sum[ACC_W];
  // acc[ACC_W] holds the carry of the last add and is cleared on every non-add cycle
  assign os_tick = acc[ACC_W];

`ifdef BAUD_GEN_CUSTOM_INC_EN
  localparam int unsigned INC_TOP_I = baud_inc(BAUD_RATE_7, CLK_FREQ, OVERSAMPLE, ACC_W);
  logic [ACC_W:0] custom_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      custom_inc <= INC_TOP_I[ACC_W:0];
      force_sw   <= 1'b0;
    end else begin
      if (inc_wr) custom_inc <= inc_wdata;
      force_sw <= inc_wr | (force_sw & (state != ST_RUN));
    end
  end

  assign next_inc = (&target) ? custom_inc : rom_inc;
`else
  assign force_sw = 1'b0;
  assign next_inc = rom_inc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      drain    <= 1'b0;
      sel_q    <= '0;
      active   <= '0;
      target   <= '0;
      inc      <= INC_RST;
      acc      <= '0;
      os_cnt   <= '0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sel_q      <= baud_switch;
      acc[ACC_W] <= 1'b0;
      bit_tick   <= 1'b0;
      mid_tick   <= 1'b0;
      case (state)
        ST_RUN: begin
          if (force_sw || (sel_q != active)) begin
            state  <= ST_SWITCH;
            busy   <= 1'b1;
            drain  <= 1'b0;
            target <= force_sw ? '1 : sel_q;
          end else if (en) begin
            acc      <= sum;
            bit_tick <= carry && (os_cnt == OS_LAST);
            mid_tick <= carry && (os_cnt == OS_MID);
            if (carry) os_cnt <= os_cnt + OS_W'(1);
          end
        end
        ST_SWITCH: begin
          if (!drain) begin
            inc    <= next_inc;
            active <= target;
            acc    <= '0;
            os_cnt <= '0;
            drain  <= 1'b1;
          end else begin
            state <= ST_RUN;
            drain <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
      // Phase realign overrides any add or carry issued this cycle
      if (sync_clr) begin
        acc      <= '0;
        os_cnt   <= '0;
        bit_tick <= 1'b0;
        mid_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_multi.sv
// Directed bench for baud_gen_multi: expectations are queued when stimulus
// is applied and popped when the corresponding DUT behaviour is measured.
module tb_baud_gen_multi;

  localparam int CLK_FREQ = 25000000;
  localparam int ACC_W    = 16;
  localparam int OS       = 16;
  localparam longint FULL = 64'd1 << ACC_W;

  logic       clk = 1'b0;
  logic       rst, en, sync_clr;
  logic [2:0] baud_switch;
  logic       os_tick, bit_tick, mid_tick, busy;

  always #5 clk = ~clk;

  baud_gen_multi #(
    .CLK_FREQ(CLK_FREQ), .ACC_W(ACC_W), .OVERSAMPLE(OS), .BAUD_SIZE(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .baud_switch(baud_switch), .sync_clr(sync_clr),
    .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick), .busy(busy)
  );

  longint exp_q[$];
  int passed = 0;
  int total  = 0;

  function automatic longint inc_of(input longint rate);
    return (((rate * OS) << (ACC_W - 8)) + (CLK_FREQ >> 9)) / (CLK_FREQ >> 8);
  endfunction

  task automatic push_exp(input longint v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input longint obs);
    longint e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%0d expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  task automatic run_count(input int n, output int os_n, output int bt_n,
                           output int mt_n, output int orphan);
    os_n = 0; bt_n = 0; mt_n = 0; orphan = 0;
    repeat (n) begin
      @(negedge clk);
      if (os_tick) os_n++;
      if (bit_tick) bt_n++;
      if (mid_tick) mt_n++;
      if ((bit_tick || mid_tick) && !os_tick) orphan++;
    end
  endtask

  task automatic wait_os(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!os_tick && cyc < limit);
    if (!os_tick) cyc = -1;
  endtask

  task automatic do_switch(input logic [2:0] idx, output int busy_len, output int tick_in_busy);
    bit seen;
    baud_switch  = idx;
    busy_len     = 0;
    tick_in_busy = 0;
    seen         = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        busy_len++;
        if (os_tick || bit_tick || mid_tick) tick_in_busy++;
      end else if (seen) begin
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int bl, tb_, os_n, bt_n, mt_n, orph, c, bad, n;
    longint inc7, inc3, exp_os, lo, hi;
    bit found;

    inc7 = inc_of(115200);
    inc3 = inc_of(9600);
    rst = 1'b1; en = 1'b0; sync_clr = 1'b0; baud_switch = 3'd7;
    repeat (3) @(negedge clk);

    // reset state
    push_exp(0);              chk("rst_outputs", {os_tick, bit_tick, mid_tick, busy});
    push_exp(inc_of(1200));   chk("rst_inc", dut.inc);
    push_exp(0);              chk("rst_acc", dut.acc);

    // test 1: 115200 over 2^ACC_W cycles
    rst = 1'b0; en = 1'b1;
    do_switch(3'd7, bl, tb_);
    push_exp(2);    chk("init_busy_len", bl);
    push_exp(0);    chk("init_tick_in_busy", tb_);
    push_exp(4832); chk("inc_115200", dut.inc);
    run_count(65536, os_n, bt_n, mt_n, orph);
    exp_os = (FULL * inc7) >> ACC_W;
    push_exp(exp_os);            chk("t1_os_ticks", os_n);
    push_exp(exp_os / OS);       chk("t1_bit_ticks", bt_n);
    push_exp((exp_os + 8) / OS); chk("t1_mid_ticks", mt_n);
    push_exp(0);                 chk("t1_orphan_ticks", orph);
    push_exp(0);                 chk("t1_acc_wrapped", dut.acc[ACC_W-1:0]);

    // test 3: switch 7->3 mid-bit
    run_count(1000, os_n, bt_n, mt_n, orph);
    push_exp((((FULL + 1000) * inc7) >> ACC_W) % OS); chk("pre_switch_os_cnt", dut.os_cnt);
    do_switch(3'd3, bl, tb_);
    push_exp(2);    chk("sw_busy_len", bl);
    push_exp(0);    chk("sw_tick_in_busy", tb_);
    push_exp(0);    chk("sw_acc_cleared", dut.acc);
    push_exp(0);    chk("sw_os_cnt_cleared", dut.os_cnt);
    push_exp(403);  chk("inc_9600", dut.inc);
    push_exp((FULL + inc3 - 1) / inc3);
    wait_os(400, c);
    chk("sw_first_tick_latency", c);

    // test 2: 9600 spacing and ticks per bit
    lo = FULL / inc3;
    hi = lo + 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      wait_os(400, c);
      if (c != lo && c != hi) bad++;
    end
    push_exp(0); chk("t2_spacing_outliers", bad);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bit_tick) break;
    end
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (os_tick) n++;
      if (bit_tick) break;
    end
    push_exp(OS); chk("t2_os_per_bit", n);

    // test 4: sync_clr coinciding with a carry at 115200
    do_switch(3'd7, bl, tb_);
    push_exp(2); chk("t4_busy_len", bl);
    repeat (((FULL + inc7 - 1) / inc7) - 1) @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    push_exp(0); chk("t4_tick_on_sync_clr", os_tick);
    sync_clr = 1'b0;
    push_exp((FULL + inc7 - 1) / inc7);
    wait_os(100, c);
    chk("t4_tick_after_sync", c);
    n = 1;
    for (int i = 0; i < 300 && !mid_tick; i++) begin
      @(negedge clk);
      if (os_tick) n++;
    end
    push_exp(OS / 2); chk("t4_mid_tick_index", n);
    for (int i = 0; i < 300 && !bit_tick; i++) begin
      @(negedge clk);
      if (os_tick) n++;
    end
    push_exp(OS); chk("t4_bit_tick_index", n);

    // test 5: en low freezes phase
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    repeat (5) @(negedge clk);
    push_exp((5 * inc7) % FULL); chk("t5_acc_before_hold", dut.acc[ACC_W-1:0]);
    en = 1'b0;
    run_count(1000, os_n, bt_n, mt_n, orph);
    push_exp(0); chk("t5_ticks_while_disabled", os_n + bt_n + mt_n);
    push_exp((5 * inc7) % FULL); chk("t5_acc_frozen", dut.acc);
    en = 1'b1;
    push_exp(((FULL + inc7 - 1) / inc7) - 5);
    wait_os(100, c);
    chk("t5_resume_latency", c);

    // test 6: async reset mid-bit
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (os_tick && dut.os_cnt == 4'd9) begin
        found = 1'b1;
        break;
      end
    end
    push_exp(1); chk("t6_reached_os_cnt9", found);
    #1 rst = 1'b1;
    #1;
    push_exp(0);            chk("t6_outputs_in_reset", {os_tick, bit_tick, mid_tick, busy});
    push_exp(0);            chk("t6_os_cnt_in_reset", dut.os_cnt);
    push_exp(inc_of(1200)); chk("t6_inc_in_reset", dut.inc);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_switch(3'd7, bl, tb_);
    push_exp(2); chk("t6_busy_len", bl);
    run_count(8192, os_n, bt_n, mt_n, orph);
    exp_os = (64'd8192 * inc7) >> ACC_W;
    push_exp(exp_os);            chk("t6_os_ticks", os_n);
    push_exp(exp_os / OS);       chk("t6_bit_ticks", bt_n);
    push_exp((exp_os + 8) / OS); chk("t6_mid_ticks", mt_n);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
